// File: rtl/iter_div.sv
// ============================================================================
// Module   : iter_div
// Purpose  : Iterative restoring radix-2 divider (DIV/DIVU/REM/REMU).
//            Optional macro DIV_EARLY_OUT_EN: single-cycle finish when |dividend| < |divisor|.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       div_ctrl,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] result_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             sel_rem_q;

  // Operand decode on the live inputs, used only on the accept edge
  logic             in_signed;
  logic             in_rem;
  logic             dd_neg;
  logic             dv_neg;
  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] dv_mag;
  logic             div_zero;
  logic             ovf;
  logic             early;
  logic [WIDTH-1:0] spec_quo;
  logic [WIDTH-1:0] spec_rem;
  logic [WIDTH-1:0] spec_res;

  assign in_signed = ~div_ctrl[0];
  assign in_rem    = div_ctrl[1];
  assign dd_neg    = in_signed & dividend[WIDTH-1];
  assign dv_neg    = in_signed & divisor[WIDTH-1];
  assign dd_mag    = dd_neg ? (~dividend + 1'b1) : dividend;
  assign dv_mag    = dv_neg ? (~divisor + 1'b1) : divisor;
  assign div_zero  = (divisor == '0);
  assign ovf       = in_signed && (dividend == MIN_NEG) && (divisor == '1);

`ifdef DIV_EARLY_OUT_EN
  assign early = !div_zero && (dd_mag < dv_mag);
`else
  assign early = 1'b0;
`endif

  assign spec_quo = div_zero ? '1 : (ovf ? MIN_NEG : '0);
  assign spec_rem = ovf ? '0 : dividend;
  assign spec_res = in_rem ? spec_rem : spec_quo;

  // The accept edge already performs the first step, so CALC needs WIDTH-1 more
  logic             in_calc;
  logic [WIDTH-1:0] step_rem_in;
  logic [WIDTH-1:0] step_quo_in;
  logic [WIDTH-1:0] step_dsr;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_rem_d;
  logic [WIDTH-1:0] step_quo_d;

  assign in_calc     = (state_q == S_CALC);
  assign step_rem_in = in_calc ? rem_q : '0;
  assign step_quo_in = in_calc ? quo_q : dd_mag;
  assign step_dsr    = in_calc ? dsr_q : dv_mag;
  assign shifted     = {step_rem_in, step_quo_in[WIDTH-1]};
  assign diff        = shifted - {1'b0, step_dsr};
  assign step_rem_d  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign step_quo_d  = {step_quo_in[WIDTH-2:0], ~diff[WIDTH]};

  logic [WIDTH-1:0] fin_quo;
  logic [WIDTH-1:0] fin_rem;
  logic [WIDTH-1:0] fin_res;

  assign fin_quo = neg_quo_q ? (~step_quo_d + 1'b1) : step_quo_d;
  assign fin_rem = neg_rem_q ? (~step_rem_d + 1'b1) : step_rem_d;
  assign fin_res = sel_rem_q ? fin_rem : fin_quo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            sel_rem_q <= in_rem;
            neg_quo_q <= dd_neg ^ dv_neg;
            neg_rem_q <= dd_neg;
            if (div_zero || ovf || early) begin
              state_q  <= S_DONE;
              result_q <= spec_res;
              cnt_q    <= '0;
            end else begin
              state_q <= S_CALC;
              rem_q   <= step_rem_d;
              quo_q   <= step_quo_d;
              dsr_q   <= dv_mag;
              cnt_q   <= CNT_W'(1);
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          rem_q <= step_rem_d;
          quo_q <= step_quo_d;
          if (cnt_q == LAST_STEP) begin
            state_q  <= S_DONE;
            result_q <= fin_res;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy   = (state_q == S_CALC);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_iter_div.sv
// ============================================================================
// Module   : tb_iter_div
// Purpose  : Directed self-checking bench for iter_div (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_div;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic             flush;
  logic [1:0]       div_ctrl;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_EARLY_OUT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 32;
`endif

  iter_div #(.WIDTH(WIDTH)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .div_ctrl (div_ctrl),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, wait for done, check result and latency
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_res, input int exp_lat);
    int  lat;
    bit  saw_busy;
    div_ctrl = op;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    lat      = 1;
    saw_busy = 1'b0;
    while (!done && lat < 100) begin
      saw_busy |= busy;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    if (exp_lat == 1) check({tag, "_busy"}, 64'(saw_busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  k;
    bit  saw_done;
    logic [WIDTH-1:0] held;

    rst      = 1'b1;
    start    = 1'b0;
    flush    = 1'b0;
    div_ctrl = '0;
    dividend = '0;
    divisor  = '0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'h0000000E, 32);
    // done must be a single-cycle pulse with result held
    @(posedge clk);
    #1;
    check("done_pulse", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("result_hold", 64'(result), 64'h0000000E);

    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'h00000002, 32);
    run_op("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32);
    run_op("rem_m7_2",   OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32);
    run_op("div_7_m2",   OP_DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32);
    run_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFFFFFE, 32'h00000001, 32);
    run_op("div_m7_m2",  OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32);
    run_op("rem_m7_m2",  OP_REM,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32);
    run_op("divu_max_1", OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32);
    run_op("divu_5_0",   OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("remu_5_0",   OP_REMU, 32'd5, 32'd0, 32'h00000005, 1);
    run_op("rem_m5_0",   OP_REM,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1);
    run_op("div_ovf",    OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",    OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Flush on the 10th CALC cycle
    @(posedge clk);
    #1;
    held     = result;
    div_ctrl = OP_DIVU;
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("flush_busy_pre", 64'(busy), 64'd1);
    repeat (9) @(posedge clk);
    #1;
    check("flush_busy_c10", 64'(busy), 64'd1);
    flush = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    saw_done = 1'b0;
    for (k = 0; k < 40; k++) begin
      saw_done |= done;
      @(posedge clk);
      #1;
    end
    check("flush_no_done", 64'(saw_done), 64'd0);
    check("flush_result", 64'(result), 64'(held));
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'h00000003, 32);

    run_op("divu_3_10", OP_DIVU, 32'd3, 32'd10, 32'h00000000, SMALL_LAT);

    // Asynchronous reset mid-CALC
    div_ctrl = OP_DIVU;
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("midcalc_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("midcalc_rst_busy", 64'(busy), 64'd0);
    check("midcalc_rst_done", 64'(done), 64'd0);
    check("midcalc_rst_result", 64'(result), 64'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_start_ignored", 64'(busy), 64'd0);
    check("rst_start_no_done", 64'(done), 64'd0);
    start = 1'b0;
    rst   = 1'b0;

    run_op("div_100_m7", OP_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32);
    run_op("rem_m100_7", OP_REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
